capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/logicap_pkg.sv | 26 ++
 rtl/capture_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logicap_pkg.sv
// Shared definitions for the logic-analyser capture controller: FSM states and
// error codes reported on err_code.
package logicap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        PRETRIG  = 3'd2,
        POSTTRIG = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } cap_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ARM_TO  = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;

    function automatic logic is_busy(input cap_state_t s);
        return (s == ARM) || (s == PRETRIG) || (s == POSTTRIG);
    endfunction

    function automatic logic is_streaming(input cap_state_t s);
        return (s == PRETRIG) || (s == POSTTRIG);
    endfunction

endpackage

// File: rtl/capture_ctrl.sv
// Capture controller: arms the capture block, streams samples into a circular
// buffer until the trigger plus post_count words, and reports done/error status.
module capture_ctrl
    import logicap_pkg::*;
#(
    parameter int size    = 32,
    parameter int saddr_w = 10,
    parameter int arm_to  = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort_req,
    input  logic [saddr_w-1:0] post_count,
    output logic               cap_arm,
    output logic               cap_abort,
    input  logic               cap_armed,
    input  logic               cap_triggered,
    input  logic               cap_overrun,
    input  logic [size-1:0]    s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    output logic               mem_we,
    output logic [saddr_w-1:0] mem_addr,
    output logic [size-1:0]    mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic               wrapped,
    output logic [saddr_w-1:0] trig_addr
);

    localparam int               TMO_W    = $clog2(arm_to + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(arm_to - 1);

    cap_state_t         state;
    cap_state_t         state_next;

    logic [saddr_w-1:0] wp;
    logic [saddr_w-1:0] wp_inc;
    logic [saddr_w-1:0] remain;
    logic [saddr_w-1:0] trig_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               wrapped_q;
    logic [1:0]         err_q;
    logic               arm_q;
    logic               abort_q;

    logic               accept;
    logic               arm_set;
    logic               abort_set;
    logic               start_load;
    logic               trig_load;
    logic               dec_remain;
    logic               tmo_inc;
    logic               err_set;
    logic [1:0]         err_val;

    assign s_tready  = is_streaming(state);
    assign accept    = s_tvalid && s_tready;
    assign wp_inc    = wp + saddr_w'(1);

    assign mem_we    = accept;
    assign mem_addr  = wp;
    assign mem_wdata = accept ? s_tdata : '0;

    assign busy      = is_busy(state);
    assign done      = (state == DONE);
    assign error     = (state == ERROR);
    assign err_code  = err_q;
    assign wrapped   = wrapped_q;
    assign trig_addr = trig_q;
    assign cap_arm   = arm_q;
    assign cap_abort = abort_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Branch order in each active state encodes the same-cycle priority:
    // abort, then overrun, then arm timeout, then trigger, then beat counting.
    always_comb begin
        state_next = state;
        arm_set    = 1'b0;
        abort_set  = 1'b0;
        start_load = 1'b0;
        trig_load  = 1'b0;
        dec_remain = 1'b0;
        tmo_inc    = 1'b0;
        err_set    = 1'b0;
        err_val    = ERR_NONE;

        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next = ARM;
                    arm_set    = 1'b1;
                    start_load = 1'b1;
                end
            end
            ARM: begin
                if (abort_req) begin
                    state_next = IDLE;
                    abort_set  = 1'b1;
                end else if (cap_armed) begin
                    state_next = PRETRIG;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = ERROR;
                    abort_set  = 1'b1;
                    err_set    = 1'b1;
                    err_val    = ERR_ARM_TO;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            PRETRIG: begin
                if (abort_req) begin
                    state_next = IDLE;
                    abort_set  = 1'b1;
                end else if (cap_overrun) begin
                    state_next = ERROR;
                    abort_set  = 1'b1;
                    err_set    = 1'b1;
                    err_val    = ERR_OVERRUN;
                end else if (cap_triggered) begin
                    trig_load  = 1'b1;
                    state_next = (remain == '0) ? DONE : POSTTRIG;
                end
            end
            POSTTRIG: begin
                if (abort_req) begin
                    state_next = IDLE;
                    abort_set  = 1'b1;
                end else if (cap_overrun) begin
                    state_next = ERROR;
                    abort_set  = 1'b1;
                    err_set    = 1'b1;
                    err_val    = ERR_OVERRUN;
                end else if (accept) begin
                    dec_remain = 1'b1;
                    if (remain == saddr_w'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A beat accepted in the trigger cycle is still pre-trigger data, so the
    // trigger address is the pointer after that beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            remain    <= '0;
            trig_q    <= '0;
            tmo_cnt   <= '0;
            wrapped_q <= 1'b0;
            err_q     <= ERR_NONE;
            arm_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            arm_q   <= arm_set;
            abort_q <= abort_set;
            if (start_load) begin
                wp        <= '0;
                remain    <= post_count;
                tmo_cnt   <= '0;
                wrapped_q <= 1'b0;
                err_q     <= ERR_NONE;
            end else begin
                if (accept) begin
                    wp <= wp_inc;
                end
                if (accept && (state == PRETRIG) && (wp == '1)) begin
                    wrapped_q <= 1'b1;
                end
                if (trig_load) begin
                    trig_q <= accept ? wp_inc : wp;
                end
                if (dec_remain) begin
                    remain <= remain - saddr_w'(1);
                end
                if (tmo_inc) begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                if (err_set) begin
                    err_q <= err_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl (saddr_w=4, arm_to=8); a small
// buffer model records every write the controller issues.
module tb_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort_req;
    logic [3:0]  post_count;
    logic        cap_arm;
    logic        cap_abort;
    logic        cap_armed;
    logic        cap_triggered;
    logic        cap_overrun;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic        wrapped;
    logic [3:0]  trig_addr;

    logic [31:0] memModel [16];
    int          wrCount;
    int          armPulses;
    int          abortPulses;
    int          readySeen;
    int          checks   = 0;
    int          failures = 0;

    capture_ctrl #(.size(32), .saddr_w(4), .arm_to(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort_req(abort_req),
        .post_count(post_count), .cap_arm(cap_arm), .cap_abort(cap_abort),
        .cap_armed(cap_armed), .cap_triggered(cap_triggered), .cap_overrun(cap_overrun),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .wrapped(wrapped), .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs just after a falling edge, records what the
    // controller does in that cycle, and returns at the next falling edge.
    task automatic applyStimulus(input logic st, input logic ab, input logic armed,
                                 input logic trig, input logic ovr, input logic tv,
                                 input logic [31:0] td);
        start         = st;
        abort_req     = ab;
        cap_armed     = armed;
        cap_triggered = trig;
        cap_overrun   = ovr;
        s_tvalid      = tv;
        s_tdata       = td;
        #2;
        if (mem_we) begin
            memModel[mem_addr] = mem_wdata;
            wrCount++;
        end
        if (cap_arm)   armPulses++;
        if (cap_abort) abortPulses++;
        if (s_tready)  readySeen++;
        @(negedge clk);
        start         = 1'b0;
        abort_req     = 1'b0;
        cap_triggered = 1'b0;
        cap_overrun   = 1'b0;
        s_tvalid      = 1'b0;
        s_tdata       = '0;
    endtask

    task automatic resetCounters();
        wrCount     = 0;
        armPulses   = 0;
        abortPulses = 0;
        readySeen   = 0;
        for (int i = 0; i < 16; i++) memModel[i] = 32'hDEAD_0000 + i;
    endtask

    task automatic runBasicCapture(input string pfx);
        resetCounters();
        post_count = 4'd4;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput({pfx, "_arm_pulse"}, cap_arm, 1);
        checkOutput({pfx, "_busy_arm"}, busy, 1);
        checkOutput({pfx, "_tready_arm"}, s_tready, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput({pfx, "_tready_pre"}, s_tready, 1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0 + i);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput({pfx, "_trig_addr_post"}, trig_addr, 5);
        checkOutput({pfx, "_busy_post"}, busy, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput({pfx, "_done_early"}, done, 0);
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hB0 + i);
        end
        checkOutput({pfx, "_done"}, done, 1);
        checkOutput({pfx, "_busy_done"}, busy, 0);
        checkOutput({pfx, "_error"}, error, 0);
        checkOutput({pfx, "_wrapped"}, wrapped, 0);
        checkOutput({pfx, "_trig_addr"}, trig_addr, 5);
        checkOutput({pfx, "_tready_done"}, s_tready, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hEE);
        checkOutput({pfx, "_write_count"}, wrCount, 9);
        checkOutput({pfx, "_arm_pulses"}, armPulses, 1);
        checkOutput({pfx, "_abort_pulses"}, abortPulses, 0);
        checkOutput({pfx, "_done_sticky"}, done, 1);
        for (int i = 0; i < 9; i++)
            checkOutput({pfx, "_mem"}, memModel[i], (i < 5) ? 32'hA0 + i : 32'hB0 + i - 5);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=hang expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        start = 1'b0; abort_req = 1'b0; post_count = '0;
        cap_armed = 1'b0; cap_triggered = 1'b0; cap_overrun = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0;
        resetCounters();
        #3;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_tready", s_tready, 0);
        checkOutput("rst_cap_arm", cap_arm, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_code", err_code, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        runBasicCapture("basic");

        // Wrap: 20 pre-trigger beats, a stray start mid-stream must be ignored
        resetCounters();
        post_count = 4'd2;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_done_cleared", done, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i == 10), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100 + i);
            if (i == 14) checkOutput("wrap_not_yet", wrapped, 0);
            if (i == 15) checkOutput("wrap_set", wrapped, 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_trig_addr", trig_addr, 4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h201);
        checkOutput("wrap_done", done, 1);
        checkOutput("wrap_wrapped", wrapped, 1);
        checkOutput("wrap_mem0_beat17", memModel[0], 32'h110);
        checkOutput("wrap_mem3", memModel[3], 32'h113);
        checkOutput("wrap_mem4_post", memModel[4], 32'h200);
        checkOutput("wrap_mem15", memModel[15], 32'h10F);
        checkOutput("wrap_write_count", wrCount, 22);

        // Arm timeout: cap_armed never rises
        resetCounters();
        post_count = 4'd4;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        n = 0;
        while (!error && n < 20) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
            n++;
        end
        checkOutput("tmo_within_bound", (n >= 7 && n <= 9), 1);
        checkOutput("tmo_error", error, 1);
        checkOutput("tmo_err_code", err_code, 1);
        checkOutput("tmo_busy", busy, 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("tmo_abort_pulses", abortPulses, 1);
        checkOutput("tmo_tready_never", readySeen, 0);
        checkOutput("tmo_no_writes", wrCount, 0);

        // Overrun during POSTTRIG: that beat is written, nothing after
        resetCounters();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("ovr_err_cleared", err_code, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h301);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h302);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h303);
        checkOutput("ovr_error", error, 1);
        checkOutput("ovr_err_code", err_code, 2);
        checkOutput("ovr_tready", s_tready, 0);
        checkOutput("ovr_done", done, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h304);
        checkOutput("ovr_write_count", wrCount, 4);
        checkOutput("ovr_mem3", memModel[3], 32'h303);
        checkOutput("ovr_abort_pulses", abortPulses, 1);
        checkOutput("ovr_trig_addr", trig_addr, 2);

        // Abort and trigger in the same cycle: abort wins
        resetCounters();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("abt_error_cleared", error, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("abt_busy", busy, 0);
        checkOutput("abt_done", done, 0);
        checkOutput("abt_error", error, 0);
        checkOutput("abt_trig_addr", trig_addr, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("abt_abort_pulses", abortPulses, 1);
        checkOutput("abt_still_idle", busy, 0);

        // Asynchronous reset while in POSTTRIG, then a fresh capture
        resetCounters();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h500);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h501);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h502);
        s_tvalid = 1'b1;
        s_tdata  = 32'h55;
        #1;
        checkOutput("mrst_pre_we", mem_we, 1);
        checkOutput("mrst_pre_trig_addr", trig_addr, 2);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mrst_busy", busy, 0);
        checkOutput("mrst_tready", s_tready, 0);
        checkOutput("mrst_we", mem_we, 0);
        checkOutput("mrst_addr", mem_addr, 0);
        checkOutput("mrst_wdata", mem_wdata, 0);
        checkOutput("mrst_trig_addr", trig_addr, 0);
        checkOutput("mrst_done", done, 0);
        checkOutput("mrst_error", error, 0);
        checkOutput("mrst_err_code", err_code, 0);
        checkOutput("mrst_wrapped", wrapped, 0);
        checkOutput("mrst_cap_arm", cap_arm, 0);
        checkOutput("mrst_cap_abort", cap_abort, 0);
        s_tvalid = 1'b0;
        s_tdata  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        runBasicCapture("again");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
